// File: rtl/branch_outcome_queue_if.sv
// Dispatch/execute/predictor-update bundle for branch_outcome_queue.
// BOQ_STATS_EN adds the stat_branches/stat_mispredicts counters.
interface branch_outcome_queue_if #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = $clog2(DEPTH)
);
  logic                alloc_valid;
  logic                alloc_pred;
  logic                alloc_ready;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                resolve_valid;
  logic [TAG_BITS-1:0] resolve_tag;
  logic                resolve_taken;
  logic                flush;
  logic                update_valid;
  logic                update_taken;
  logic                mispredict;
  logic [TAG_BITS:0]   count;
`ifdef BOQ_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output alloc_valid, alloc_pred, resolve_valid, resolve_tag, resolve_taken, flush,
    input  alloc_ready, alloc_tag, update_valid, update_taken, mispredict, count,
    input  stat_branches, stat_mispredicts
  );
  modport slave (
    input  alloc_valid, alloc_pred, resolve_valid, resolve_tag, resolve_taken, flush,
    output alloc_ready, alloc_tag, update_valid, update_taken, mispredict, count,
    output stat_branches, stat_mispredicts
  );
`else
  modport master (
    output alloc_valid, alloc_pred, resolve_valid, resolve_tag, resolve_taken, flush,
    input  alloc_ready, alloc_tag, update_valid, update_taken, mispredict, count
  );
  modport slave (
    input  alloc_valid, alloc_pred, resolve_valid, resolve_tag, resolve_taken, flush,
    output alloc_ready, alloc_tag, update_valid, update_taken, mispredict, count
  );
`endif
endinterface

// File: rtl/branch_outcome_queue.sv
// In-order queue of in-flight branches feeding gshare updates; mispredicts squash younger entries.
// Optional BOQ_STATS_EN adds 32-bit retired-branch and mispredict counters.
module branch_outcome_queue #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  branch_outcome_queue_if.slave bus
);
  localparam logic [TAG_BITS:0] PTR_ONE = (TAG_BITS+1)'(1);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    pred_q, pred_d;
  logic [DEPTH-1:0]    resolved_q, resolved_d;
  logic [DEPTH-1:0]    taken_q, taken_d;
  logic [TAG_BITS:0]   head_q, head_d;
  logic [TAG_BITS:0]   tail_q, tail_d;
  logic                upd_valid_q, upd_valid_d;
  logic                upd_taken_q, upd_taken_d;
  logic                mp_q, mp_d;

  logic [TAG_BITS-1:0] hidx, tidx;
  logic                full, retire, retire_mp, resolve_hit, alloc_fire;

  assign hidx      = head_q[TAG_BITS-1:0];
  assign tidx      = tail_q[TAG_BITS-1:0];
  assign full      = (hidx == tidx) && (head_q[TAG_BITS] != tail_q[TAG_BITS]);
  assign retire    = valid_q[hidx] && resolved_q[hidx];
  assign retire_mp = retire && (taken_q[hidx] != pred_q[hidx]);

  assign bus.alloc_ready = !full && !bus.flush && !retire_mp;
  assign bus.alloc_tag   = tidx;
  assign bus.count       = tail_q - head_q;

  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
  assign resolve_hit = bus.resolve_valid && valid_q[bus.resolve_tag] && !resolved_q[bus.resolve_tag];

  always_comb begin
    valid_d     = valid_q;
    pred_d      = pred_q;
    resolved_d  = resolved_q;
    taken_d     = taken_q;
    head_d      = head_q;
    tail_d      = tail_q;
    upd_valid_d = 1'b0;
    upd_taken_d = upd_taken_q;
    mp_d        = 1'b0;
    if (bus.flush) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
    end else if (retire_mp) begin
      // Everything younger than the mispredicted head is wrong-path: drop it all.
      valid_d     = '0;
      resolved_d  = '0;
      head_d      = tail_q;
      upd_valid_d = 1'b1;
      upd_taken_d = taken_q[hidx];
      mp_d        = 1'b1;
    end else begin
      if (retire) begin
        valid_d[hidx]    = 1'b0;
        resolved_d[hidx] = 1'b0;
        head_d           = head_q + PTR_ONE;
        upd_valid_d      = 1'b1;
        upd_taken_d      = taken_q[hidx];
      end
      // A resolve never targets the retiring head (already resolved) nor the tail (invalid).
      if (resolve_hit) begin
        resolved_d[bus.resolve_tag] = 1'b1;
        taken_d[bus.resolve_tag]    = bus.resolve_taken;
      end
      if (alloc_fire) begin
        valid_d[tidx]    = 1'b1;
        pred_d[tidx]     = bus.alloc_pred;
        resolved_d[tidx] = 1'b0;
        tail_d           = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      pred_q      <= '0;
      resolved_q  <= '0;
      taken_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      mp_q        <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      resolved_q  <= resolved_d;
      taken_q     <= taken_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      mp_q        <= mp_d;
    end
  end

  assign bus.update_valid = upd_valid_q;
  assign bus.update_taken = upd_taken_q;
  assign bus.mispredict   = mp_q;

`ifdef BOQ_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (upd_valid_q) stat_br_q <= stat_br_q + 32'd1;
      if (mp_q)        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_outcome_queue.sv
// Scoreboard bench for branch_outcome_queue: allocations queue expected updates, the monitor retires them.
module tb_branch_outcome_queue;
  localparam int DEPTH = 8;

  typedef struct {
    int   tag;
    logic pred;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_outcome_queue_if #(.DEPTH(DEPTH)) bus ();
  branch_outcome_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   vectors     = 0;
  int   miscompares = 0;
  rec_t sb[$];
  logic m_taken [DEPTH];
  int   m_tail = 0;
  int   cyc    = 0;
  int   n_upd  = 0;
  int   n_mp   = 0;
  int   upd_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Retired-branch monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rec_t r;
    logic exp_mp;
    cyc++;
    if (bus.update_valid === 1'b1) begin
      n_upd++;
      upd_cyc.push_back(cyc);
      if (bus.mispredict === 1'b1) n_mp++;
      if (sb.size() == 0) check_val("spurious_update", 32'd1, 32'd0);
      else begin
        r = sb.pop_front();
        exp_mp = (m_taken[r.tag] != r.pred);
        check_val("update_taken", 32'(bus.update_taken), 32'(m_taken[r.tag]));
        check_val("mispredict", 32'(bus.mispredict), 32'(exp_mp));
        if (exp_mp === 1'b1) sb.delete();
      end
    end else if (bus.mispredict !== 1'b0) begin
      check_val("stray_mispredict", 32'(bus.mispredict), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_one(input logic pred, input logic exp_ready);
    bus.alloc_valid = 1'b1;
    bus.alloc_pred  = pred;
    #1;
    check_val("alloc_ready", 32'(bus.alloc_ready), 32'(exp_ready));
    if (exp_ready) begin
      check_val("alloc_tag", 32'(bus.alloc_tag), 32'(m_tail));
      sb.push_back('{tag: m_tail, pred: pred});
      m_taken[m_tail] = 1'bx;
      m_tail = (m_tail + 1) % DEPTH;
    end
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic resolve_one(input int tag, input logic taken, input logic effective);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = tag[2:0];
    bus.resolve_taken = taken;
    if (effective) m_taken[tag] = taken;
    step();
    bus.resolve_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check_val(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_count"}, 32'(bus.count), 32'd0);
    check_val({tag, "_ready"}, 32'(bus.alloc_ready), 32'd1);
    check_val({tag, "_tag"}, 32'(bus.alloc_tag), 32'd0);
    check_val({tag, "_uv"}, 32'(bus.update_valid), 32'd0);
    check_val({tag, "_ut"}, 32'(bus.update_taken), 32'd0);
    check_val({tag, "_mp"}, 32'(bus.mispredict), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r, nb, stray;
    bus.alloc_valid   = 1'b0;
    bus.alloc_pred    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_tag   = '0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
    #12;
    check_reset_outputs("reset");
    step();
    rst = 1'b1;

    // Fill / drain
    base = m_tail;
    for (int i = 0; i < DEPTH; i++) alloc_one(1'b1, 1'b1);
    check_val("fill_count", 32'(bus.count), 32'(DEPTH));
    alloc_one(1'b1, 1'b0);
    nb = n_upd;
    r  = cyc;
    for (int i = 0; i < DEPTH; i++) resolve_one((base + i) % DEPTH, 1'b1, 1'b1);
    wait_drain("fill_drain");
    check_val("fill_pulses", 32'(n_upd - nb), 32'(DEPTH));
    check_val("fill_first_cyc", 32'(upd_cyc[nb]), 32'(r + 3));
    check_val("fill_last_cyc", 32'(upd_cyc[nb + DEPTH - 1]), 32'(r + DEPTH + 2));
    check_val("fill_count_end", 32'(bus.count), 32'd0);

    // Out-of-order resolve, plus a repeat resolve that must be ignored
    base = m_tail;
    alloc_one(1'b0, 1'b1);
    alloc_one(1'b1, 1'b1);
    alloc_one(1'b1, 1'b1);
    nb = n_upd;
    resolve_one((base + 2) % DEPTH, 1'b1, 1'b1);
    resolve_one((base + 2) % DEPTH, 1'b0, 1'b0);
    resolve_one((base + 1) % DEPTH, 1'b1, 1'b1);
    step();
    step();
    check_val("ooo_hold", 32'(n_upd), 32'(nb));
    r = cyc;
    resolve_one(base, 1'b0, 1'b1);
    wait_drain("ooo_drain");
    check_val("ooo_c0", 32'(upd_cyc[nb]), 32'(r + 3));
    check_val("ooo_c1", 32'(upd_cyc[nb + 1]), 32'(r + 4));
    check_val("ooo_c2", 32'(upd_cyc[nb + 2]), 32'(r + 5));

    // Mispredict: allocation attempted in the recovery cycle is dropped
    base = m_tail;
    alloc_one(1'b1, 1'b1);
    alloc_one(1'b0, 1'b1);
    alloc_one(1'b1, 1'b1);
    nb = n_mp;
    resolve_one(base, 1'b0, 1'b1);
    alloc_one(1'b1, 1'b0);
    check_val("mp_count", 32'(bus.count), 32'd0);
    check_val("mp_tail", 32'(bus.alloc_tag), 32'(m_tail));
    wait_drain("mp_drain");
    check_val("mp_pulses", 32'(n_mp - nb), 32'd1);

    // Flush beats a ready-to-retire head
    base = m_tail;
    alloc_one(1'b1, 1'b1);
    alloc_one(1'b1, 1'b1);
    resolve_one(base, 1'b1, 1'b1);
    bus.flush = 1'b1;
    sb.delete();
    m_tail = 0;
    #1;
    check_val("flush_ready", 32'(bus.alloc_ready), 32'd0);
    step();
    bus.flush = 1'b0;
    check_val("flush_count", 32'(bus.count), 32'd0);
    check_val("flush_tag", 32'(bus.alloc_tag), 32'd0);
    step();
    step();
    step();

    // Wrap-around rounds with one stray resolve to an unallocated tag
    for (int i = 0; i < 20; i++) begin
      base = m_tail;
      alloc_one(1'($urandom_range(1)), 1'b1);
      if (i == 10) begin
        stray = (base + 3) % DEPTH;
        resolve_one(stray, 1'b1, 1'b0);
        check_val("stray_count", 32'(bus.count), 32'd1);
      end
      resolve_one(base, 1'($urandom_range(1)), 1'b1);
      wait_drain("wrap_drain");
    end
    check_val("wrap_tail", 32'(bus.alloc_tag), 32'(m_tail));
    step();
`ifdef BOQ_STATS_EN
    check_val("stat_branches", bus.stat_branches, 32'(n_upd));
    check_val("stat_mispredicts", bus.stat_mispredicts, 32'(n_mp));
`endif

    // Async reset with entries held, head resolved and a taken update latched
    base = m_tail;
    alloc_one(1'b1, 1'b1);
    resolve_one(base, 1'b1, 1'b1);
    wait_drain("pre_rst_drain");
    base = m_tail;
    for (int i = 0; i < 4; i++) alloc_one(1'b1, 1'b1);
    resolve_one(base, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    sb.delete();
    m_tail = 0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst = 1'b1;
    alloc_one(1'b0, 1'b1);
    resolve_one(0, 1'b0, 1'b1);
    wait_drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_outcome_queue.md
# branch_outcome_queue

In-order queue of in-flight conditional branches, one entry per branch, between dispatch and the gshare predictor's update port. Dispatch allocates an entry holding the predicted direction. Execute writes the actual outcome by tag, out of order. The head retires in program order, drives one predictor update per branch (`prediction_valid`/`prediction_result`), and flags mispredicts.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `TAG_BITS`, `$clog2(DEPTH)`: entry tag width.

- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `alloc_valid` in 1: dispatch allocates one branch entry.
- `alloc_pred` in 1: predicted direction captured into the entry (the predictor's `prediction`).
- `alloc_ready` out 1: allocation accepted this cycle.
- `alloc_tag` out TAG_BITS: tag of the entry an accepted allocation receives (the tail index).
- `resolve_valid` in 1: execute reports an outcome.
- `resolve_tag` in TAG_BITS: entry being resolved.
- `resolve_taken` in 1: actual direction.
- `flush` in 1: discard all entries.
- `update_valid` out 1: registered, one-cycle pulse per retired branch; drives predictor `prediction_valid`.
- `update_taken` out 1: registered actual direction of the retired branch; drives `prediction_result`.
- `mispredict` out 1: registered, one-cycle pulse when the retired branch's actual direction differs from its prediction.
- `count` out TAG_BITS+1: number of occupied entries.

## Operation
- **Per-entry state:** `valid`, `pred`, `resolved`, `taken`.
- **Pointers:** head and tail are TAG_BITS+1 wide, with a wrap bit.
  - Full when indices are equal and wrap bits differ.
  - Empty when head equals tail.
- **Allocate:** `alloc_ready = !full && !flush && !retire_mp`.
  - On `alloc_valid && alloc_ready`: write `valid=1`, `pred=alloc_pred`, `resolved=0` at the tail; tail increments.
  - `alloc_tag` always shows the current tail index.
- **Resolve:** on `resolve_valid` where the addressed entry is valid and unresolved, set `resolved=1` and `taken=resolve_taken`.
  - Resolves to invalid or already-resolved entries are ignored.
- **Retire:** `retire = head entry valid && resolved` (state at cycle start); at most one per cycle.
  - On retire, clear the head entry, increment head, and register `update_valid=1`, `update_taken=taken`, `mispredict=(taken!=pred)`.
- **Mispredict recovery:** `retire_mp = retire && taken!=pred`.
  - At that edge all entries are invalidated and head = tail, because younger entries are wrong-path.
  - Any allocation or resolve in that cycle is dropped.
- **Flush:** clears all entries and sets head = tail = 0 at the next edge.
  - Has priority over retire, resolve and allocate; no update is emitted for that cycle.
- **Same-cycle events:**
  - Allocate and retire in the same cycle are both performed.
  - Resolve and retire of *different* entries in the same cycle are both performed.

## Timing
- **Reset values:** all entries invalid, head = tail = 0, `update_valid=0`, `update_taken=0`, `mispredict=0`, `count=0`, `alloc_ready=1`, `alloc_tag=0`.
- Reset asserted mid-operation discards all state immediately; no update pulse.
- **Latency:**
  - An entry resolved at edge E (with `resolve_valid` in cycle c) retires at edge E+1.
  - `update_valid` is high in cycle c+2, provided the entry is at the head.
  - No resolve-to-retire bypass.
- **Throughput:** with the head chain resolved, one retire per cycle.
- **Combinational outputs:** `alloc_ready`, `alloc_tag` and `count` are combinational from registered state and `flush`; `count` reflects state only.
- `update_valid` and `mispredict` never stay high more than one cycle per retired branch.

## Configuration
- **`BOQ_STATS_EN` defined:** adds outputs `stat_branches` (out 32) and `stat_mispredicts` (out 32).
  - Increment on each `update_valid` and `mispredict` pulse respectively.
  - Wrap modulo 2^32; reset to 0; not cleared by `flush`.
- **Undefined:** the ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Fill/drain:** DEPTH=8, allocate 8 with `pred=1`, resolve tags 0..7 `taken=1` in order.
  - `alloc_ready=0` with `count=8`.
  - 8 consecutive `update_valid` pulses with `update_taken=1`, `mispredict=0`; `count` returns to 0.
- **Out-of-order resolve:** allocate tags 0,1,2; resolve 2, then 1, then 0.
  - No update until tag 0 resolves; then 3 pulses on consecutive cycles in order 0,1,2.
- **Mispredict:** allocate 0 (`pred=1`), 1, 2; resolve 0 with `taken=0` while allocating in the same cycle.
  - One pulse with `mispredict=1`, `update_taken=0`; next cycle `count=0`; that allocation is dropped.
- **Flush priority:** head resolved and `flush=1` in the same cycle.
  - No `update_valid`; `count=0`; `alloc_tag=0` the next cycle.
- **Wrap-around and invalid resolve:** 20 allocate/resolve/retire rounds, plus a resolve of an unallocated tag.
  - Tags wrap 7→0; the stray resolve has no effect.
  - With `BOQ_STATS_EN`: `stat_branches` equals the retire count.
- **Async reset:** assert `rst=0` between edges with 4 entries held.
  - All outputs reach their reset values immediately; the first allocation after release gets `alloc_tag=0`.
